// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use bubbles, memory wait stalls,
// mispredict flushes and the halt drain. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module hazard_ctrl #(
  parameter int HALT_DRAIN = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ID_p0_addr,
  input  logic [3:0]       ID_p1_addr,
  input  logic             ID_cntrl_re0,
  input  logic             ID_cntrl_re1,
  input  logic             ID_hlt,
  input  logic             EX_cntrl_mem_read,
  input  logic [3:0]       EX_reg_write_addr,
  input  logic             EX_mispredict,
  input  logic             mem_busy,
  output logic             stall,
  output logic             flush,
  output logic             insert_nop,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [2:0] DRAIN_INIT = 3'(HALT_DRAIN - 1);

  logic [1:0] state, state_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;
  logic       lu;

  // R0 is hardwired to zero, so a load targeting it can never create a hazard.
  assign lu = EX_cntrl_mem_read && (EX_reg_write_addr != 4'd0) &&
              ((ID_cntrl_re0 && (ID_p0_addr == EX_reg_write_addr)) ||
               (ID_cntrl_re1 && (ID_p1_addr == EX_reg_write_addr)));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall         = 1'b0;
    flush         = 1'b0;
    insert_nop    = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    halted        = 1'b0;

    case (state)
      RUN: begin
        if (mem_busy) begin
          stall      = 1'b1;
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
        end else if (EX_mispredict) begin
          flush = 1'b1;
        end else if (lu) begin
          insert_nop = 1'b1;
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
        end else if (ID_hlt) begin
          pc_hold       = 1'b1;
          if_id_hold    = 1'b1;
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_INIT;
        end
      end
      DRAIN: begin
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        if (mem_busy) begin
          stall = 1'b1;
        end else if (EX_mispredict) begin
          // The HLT was fetched down the wrong path; resume normal execution.
          flush     = 1'b1;
          state_nxt = RUN;
        end else if (drain_cnt == 3'd0) begin
          state_nxt = HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt - 3'd1;
        end
      end
      HALTED: begin
        halted     = 1'b1;
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
      end
      default: state_nxt = RUN;
    endcase

    if (!rst_n) begin
      stall      = 1'b0;
      flush      = 1'b0;
      insert_nop = 1'b0;
      pc_hold    = 1'b0;
      if_id_hold = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; output vector order is
// {stall, flush, insert_nop, pc_hold, if_id_hold, halted}.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ID_p0_addr, ID_p1_addr, EX_reg_write_addr;
  logic       ID_cntrl_re0, ID_cntrl_re1, ID_hlt;
  logic       EX_cntrl_mem_read, EX_mispredict, mem_busy;
  logic       stall, flush, insert_nop, pc_hold, if_id_hold, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

  logic [5:0] outs;
  assign outs = {stall, flush, insert_nop, pc_hold, if_id_hold, halted};

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.HALT_DRAIN(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_p0_addr(ID_p0_addr), .ID_p1_addr(ID_p1_addr),
    .ID_cntrl_re0(ID_cntrl_re0), .ID_cntrl_re1(ID_cntrl_re1), .ID_hlt(ID_hlt),
    .EX_cntrl_mem_read(EX_cntrl_mem_read), .EX_reg_write_addr(EX_reg_write_addr),
    .EX_mispredict(EX_mispredict), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .insert_nop(insert_nop),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic chk(input string tag, input logic [5:0] exp);
    #1;
    check(tag, 32'(outs), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ID_p0_addr = 4'd0; ID_p1_addr = 4'd0; EX_reg_write_addr = 4'd0;
    ID_cntrl_re0 = 1'b0; ID_cntrl_re1 = 1'b0; ID_hlt = 1'b0;
    EX_cntrl_mem_read = 1'b0; EX_mispredict = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_busy = 1'b1; EX_mispredict = 1'b1;
    chk("reset_forces_zero", 6'b000000);
    step();
    clr();
    rst_n = 1'b1;
  endtask

  task automatic lu_p1(input string tag);
    EX_cntrl_mem_read = 1'b1; EX_reg_write_addr = 4'd5;
    ID_p1_addr = 4'd5; ID_cntrl_re1 = 1'b1;
    chk(tag, 6'b001110);
    step();
    EX_cntrl_mem_read = 1'b0;
    chk({tag, "_bubble_gone"}, 6'b000000);
    step();
    clr();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    step();
    do_reset();
    chk("idle_after_reset", 6'b000000);

    // Load-use detection
    lu_p1("lu_p1");
    EX_cntrl_mem_read = 1'b1; EX_reg_write_addr = 4'd9; ID_p0_addr = 4'd9; ID_cntrl_re0 = 1'b1;
    chk("lu_p0", 6'b001110);
    ID_cntrl_re0 = 1'b0; ID_p1_addr = 4'd9;
    chk("lu_no_read_enable", 6'b000000);
    EX_reg_write_addr = 4'd0; ID_p0_addr = 4'd0; ID_p1_addr = 4'd0;
    ID_cntrl_re0 = 1'b1; ID_cntrl_re1 = 1'b1;
    chk("lu_r0_ignored", 6'b000000);
    EX_reg_write_addr = 4'd3; ID_p0_addr = 4'd3; EX_cntrl_mem_read = 1'b0;
    chk("lu_not_load", 6'b000000);
    step();
    clr();

    // Mispredict held behind memory wait
    mem_busy = 1'b1; EX_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy_mispredict_%0d", i), 6'b100110);
      step();
    end
    mem_busy = 1'b0;
    chk("flush_after_busy", 6'b010000);
    step();
    clr();

    // HLT loses to a concurrent load-use, then is accepted and drains
    ID_hlt = 1'b1; EX_cntrl_mem_read = 1'b1; EX_reg_write_addr = 4'd2;
    ID_p0_addr = 4'd2; ID_cntrl_re0 = 1'b1;
    chk("hlt_vs_lu", 6'b001110);
    step();
    EX_cntrl_mem_read = 1'b0;
    chk("hlt_accept", 6'b000110);
    step();
    clr();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("drain_%0d", i), 6'b000110);
      step();
    end
    chk("halted_rises", 6'b000111);
    for (int i = 0; i < 6; i++) begin
      step();
      {ID_hlt, EX_cntrl_mem_read, EX_mispredict, mem_busy} = 4'($urandom);
      {ID_cntrl_re0, ID_cntrl_re1} = 2'($urandom);
      {ID_p0_addr, ID_p1_addr, EX_reg_write_addr} = 12'($urandom);
      chk($sformatf("halted_sticky_%0d", i), 6'b000111);
    end

    // Reset out of HALTED, then load-use works again
    do_reset();
    chk("run_after_reset", 6'b000000);
    lu_p1("lu_p1_after_reset");

    // Wrong-path halt
    ID_hlt = 1'b1;
    chk("wp_hlt_accept", 6'b000110);
    step();
    ID_hlt = 1'b0;
    chk("wp_drain_1", 6'b000110);
    step();
    EX_mispredict = 1'b1;
    chk("wp_flush", 6'b010110);
    step();
    clr();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wp_back_in_run_%0d", i), 6'b000000);
      step();
    end

    // Memory wait during drain extends it by one cycle
    ID_hlt = 1'b1;
    chk("mb_hlt_accept", 6'b000110);
    step();
    ID_hlt = 1'b0; mem_busy = 1'b1;
    chk("mb_drain_stall", 6'b100110);
    step();
    mem_busy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mb_drain_%0d", i), 6'b000110);
      step();
    end
    chk("mb_halted", 6'b000111);
    do_reset();

`ifdef HAZARD_PERF_CNT_EN
    check("cnt_reset_stall", 32'(stall_cycles), 32'd0);
    check("cnt_reset_flush", 32'(flush_count), 32'd0);
    mem_busy = 1'b1;
    repeat (5) step();
    mem_busy = 1'b0; EX_mispredict = 1'b1;
    repeat (2) step();
    clr();
    #1;
    check("cnt_stall_5", 32'(stall_cycles), 32'd5);
    check("cnt_flush_2", 32'(flush_count), 32'd2);
    mem_busy = 1'b1;
    repeat (65534 - 5) step();
    mem_busy = 1'b0;
    #1;
    check("cnt_stall_fffe", 32'(stall_cycles), 32'hFFFE);
    mem_busy = 1'b1;
    repeat (3) step();
    clr();
    #1;
    check("cnt_stall_saturate", 32'(stall_cycles), 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
